// File: rtl/dice_result_display_if.sv
// Signal bundle between the dice result display and its neighbours:
// roll button and live throw in, display pins and roll statistics out.
interface dice_result_display_if #(
    parameter int COUNT_W = 8
);
    logic               button;
    logic [2:0]         throw;
    logic [6:0]         seg;
    logic [2:0]         result;
    logic               result_valid;
    logic               doubles;
    logic [COUNT_W-1:0] roll_count;
    logic               rolling;

    modport master (
        output button, throw,
        input  seg, result, result_valid, doubles, roll_count, rolling
    );

    modport slave (
        input  button, throw,
        output seg, result, result_valid, doubles, roll_count, rolling
    );
endinterface

// File: rtl/dice_result_display.sv
// Dice result display: blinks the live throw while the button is held, captures
// the throw on release, then shows it on a 7-segment digit with doubles/roll stats.
module dice_result_display #(
    parameter int BLINK_DIV = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dice_result_display_if.slave  dif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         blink_cnt;
    logic               blink_on;
    logic [2:0]         result;
    logic               result_valid;
    logic               doubles;
    logic               prev_valid;
    logic [COUNT_W-1:0] roll_count;
    logic [2:0]         throw_san;
    logic [6:0]         seg;

    // The dice may momentarily present 0 or 7; both read as a one.
    function automatic logic [2:0] san(input logic [2:0] t);
        return (t == 3'd0 || t == 3'd7) ? 3'd1 : t;
    endfunction

    function automatic logic [6:0] digit(input logic [2:0] d);
        logic [6:0] code;
        case (d)
            3'd1:    code = 7'h06;
            3'd2:    code = 7'h5B;
            3'd3:    code = 7'h4F;
            3'd4:    code = 7'h66;
            3'd5:    code = 7'h6D;
            3'd6:    code = 7'h7D;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + COUNT_W'(1);
    endfunction

    assign throw_san = san(dif.throw);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dif.button)  state_nxt = ROLLING;
            ROLLING: if (!dif.button) state_nxt = SHOW;
            SHOW:    if (dif.button)  state_nxt = ROLLING;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            blink_cnt    <= 8'd0;
            blink_on     <= 1'b1;
            result       <= 3'd0;
            result_valid <= 1'b0;
            doubles      <= 1'b0;
            prev_valid   <= 1'b0;
            roll_count   <= '0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;

            // Every new roll starts in the lit blink phase.
            if (state != ROLLING && state_nxt == ROLLING) begin
                blink_cnt <= 8'd0;
                blink_on  <= 1'b1;
            end else if (state == ROLLING && dif.button) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= 8'd0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end

            if (state == ROLLING && !dif.button) begin
                result       <= throw_san;
                result_valid <= 1'b1;
                doubles      <= prev_valid && (throw_san == result);
                prev_valid   <= 1'b1;
                roll_count   <= sat_inc(roll_count);
            end
        end
    end

    always_comb begin
        seg = 7'h00;
        case (state)
            IDLE:    seg = 7'h40;
            ROLLING: seg = blink_on ? digit(throw_san) : 7'h00;
            SHOW:    seg = digit(result);
            default: seg = 7'h40;
        endcase
    end

    assign dif.seg          = seg;
    assign dif.result       = result;
    assign dif.result_valid = result_valid;
    assign dif.doubles      = doubles;
    assign dif.roll_count   = roll_count;
    assign dif.rolling      = (state == ROLLING);

endmodule

// File: tb/tb_dice_result_display.sv
// Bench for dice_result_display: two builds (BLINK_DIV=4/COUNT_W=8 and
// BLINK_DIV=3/COUNT_W=2) driven in lockstep against a behavioural roll model.
module tb_dice_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] throw;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dice_result_display_if #(.COUNT_W(8)) if0 ();
    dice_result_display_if #(.COUNT_W(2)) if1 ();

    assign if0.button = button;
    assign if0.throw  = throw;
    assign if1.button = button;
    assign if1.throw  = throw;

    dice_result_display #(.BLINK_DIV(4), .COUNT_W(8)) dut0 (.clk(clk), .rst(rst), .dif(if0.slave));
    dice_result_display #(.BLINK_DIV(3), .COUNT_W(2)) dut1 (.clk(clk), .rst(rst), .dif(if1.slave));

    // Observed outputs packed as {seg, result, result_valid, doubles, rolling, roll_count[7:0]}
    logic [20:0] obs [2];
    assign obs[0] = {if0.seg, if0.result, if0.result_valid, if0.doubles, if0.rolling, if0.roll_count};
    assign obs[1] = {if1.seg, if1.result, if1.result_valid, if1.doubles, if1.rolling, 6'd0, if1.roll_count};

    // Behavioural model: phase 0=no result yet, 1=button held, 2=showing result.
    int m_phase [2];
    int m_held  [2];
    int m_res   [2];
    int m_vld   [2];
    int m_dbl   [2];
    int m_have  [2];
    int m_cnt   [2];
    int blink_div [2] = '{4, 3};
    int cnt_max   [2] = '{255, 3};
    int dig       [8] = '{0, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 0};

    function automatic int sanm(input int t);
        return (t >= 1 && t <= 6) ? t : 1;
    endfunction

    function automatic logic [20:0] exp_vec(input int i);
        int s;
        if (m_phase[i] == 0)
            s = 'h40;
        else if (m_phase[i] == 1)
            s = ((m_held[i] / blink_div[i]) % 2 == 0) ? dig[sanm(int'(throw))] : 0;
        else
            s = dig[m_res[i]];
        return {7'(s), 3'(m_res[i]), 1'(m_vld[i]), 1'(m_dbl[i]), (m_phase[i] == 1), 8'(m_cnt[i])};
    endfunction

    task automatic cycle(input logic b, input logic [2:0] t, input logic r);
        int s;
        button = b;
        throw  = t;
        rst    = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_phase[i] = 0; m_held[i] = 0; m_res[i] = 0; m_vld[i] = 0;
                m_dbl[i] = 0;   m_have[i] = 0; m_cnt[i] = 0;
            end else begin
                m_vld[i] = 0;
                if (m_phase[i] == 1 && !b) begin
                    s = sanm(int'(t));
                    m_dbl[i]  = (m_have[i] != 0 && s == m_res[i]) ? 1 : 0;
                    m_have[i] = 1;
                    m_res[i]  = s;
                    m_vld[i]  = 1;
                    if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                    m_phase[i] = 2;
                end else if (m_phase[i] == 1) begin
                    m_held[i]++;
                end else if (b) begin
                    m_phase[i] = 1;
                    m_held[i]  = 0;
                end
            end
        end
    endtask

    task automatic roll(input int n, input logic [2:0] t);
        for (int j = 0; j < n; j++) cycle(1'b1, 3'($urandom_range(0, 7)), 1'b0);
        cycle(1'b0, t, 1'b0);
    endtask

    task automatic test_reset();
        for (int j = 0; j < 2; j++) begin
            cycle(1'b1, 3'd4, 1'b1);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d: got %h expected %h", i, j, obs[i], exp_vec(i));
                end
            end
            n_checks++;
            if (if0.seg !== 7'h40 || if0.result !== 3'd0 || if0.roll_count !== 8'd0 || if0.result_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: seg=%h result=%0d count=%0d valid=%b, expected seg=40 result=0 count=0 valid=0",
                         if0.seg, if0.result, if0.roll_count, if0.result_valid);
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] want;
        for (int j = 0; j < 10; j++) begin
            cycle(1'b1, 3'd3, 1'b0);
            want = (j < 4 || j >= 8) ? 7'h4F : 7'h00;
            n_checks++;
            if (if0.seg !== want || if0.rolling !== 1'b1) begin
                n_fail++;
                $display("FAIL blink cyc%0d: seg=%h rolling=%b, expected seg=%h rolling=1", j, if0.seg, if0.rolling, want);
            end
            n_checks++;
            if (obs[1] !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL blink dut1 cyc%0d: got %h expected %h", j, obs[1], exp_vec(1));
            end
        end
        cycle(1'b0, 3'd3, 1'b0);
        n_checks++;
        if (if0.result_valid !== 1'b1 || if0.result !== 3'd3 || if0.seg !== 7'h4F || if0.roll_count !== 8'd1 || if0.doubles !== 1'b0) begin
            n_fail++;
            $display("FAIL first_capture: valid=%b result=%0d seg=%h count=%0d dbl=%b, expected 1 3 4f 1 0",
                     if0.result_valid, if0.result, if0.seg, if0.roll_count, if0.doubles);
        end
        cycle(1'b0, 3'($urandom_range(0, 7)), 1'b0);
        n_checks++;
        if (if0.result_valid !== 1'b0 || if0.seg !== 7'h4F || obs[0] !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL valid_pulse_end: got %h expected %h", obs[0], exp_vec(0));
        end
    endtask

    task automatic test_doubles();
        roll($urandom_range(1, 6), 3'd3);
        n_checks++;
        if (if0.doubles !== 1'b1 || if0.roll_count !== 8'd2 || obs[0] !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL doubles_3_3: got %h expected %h", obs[0], exp_vec(0));
        end
        roll($urandom_range(1, 6), 3'd5);
        n_checks++;
        if (if0.doubles !== 1'b0 || if0.result !== 3'd5 || if0.seg !== 7'h6D || obs[0] !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL doubles_3_5: got %h expected %h", obs[0], exp_vec(0));
        end
        n_checks++;
        if (obs[1] !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL doubles dut1: got %h expected %h", obs[1], exp_vec(1));
        end
    endtask

    task automatic test_sanitise();
        roll($urandom_range(1, 6), 3'd0);
        n_checks++;
        if (if0.result !== 3'd1 || if0.seg !== 7'h06 || obs[0] !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL sanitise_0: got %h expected %h", obs[0], exp_vec(0));
        end
        roll($urandom_range(1, 6), 3'd7);
        n_checks++;
        if (if0.result !== 3'd1 || if0.seg !== 7'h06 || if0.doubles !== 1'b1 || obs[0] !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL sanitise_7: got %h expected %h", obs[0], exp_vec(0));
        end
    endtask

    task automatic test_reset_mid_roll();
        for (int j = 0; j < 3; j++) cycle(1'b1, 3'd2, 1'b0);
        cycle(1'b1, 3'd2, 1'b1);
        n_checks++;
        if (if0.rolling !== 1'b0 || if0.seg !== 7'h40 || if0.result_valid !== 1'b0 || if0.roll_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_roll: rolling=%b seg=%h valid=%b count=%0d, expected 0 40 0 0",
                     if0.rolling, if0.seg, if0.result_valid, if0.roll_count);
        end
        for (int j = 0; j < 2; j++) begin
            cycle(1'b0, 3'd2, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i) || obs[i][13] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_capture_after_reset dut%0d: got %h expected %h", i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        cycle(1'b0, 3'd0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            roll($urandom_range(1, 4), 3'($urandom_range(0, 7)));
            n_checks++;
            if (if1.roll_count !== want[r] || obs[1] !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL saturation roll%0d: count=%0d expected %0d (vec %h vs %h)",
                         r, if1.roll_count, want[r], obs[1], exp_vec(1));
            end
            n_checks++;
            if (if0.roll_count !== 8'(r + 1)) begin
                n_fail++;
                $display("FAIL count8 roll%0d: got %0d expected %0d", r, if0.roll_count, r + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 8; j++) begin
            cycle(pat[j], 3'($urandom_range(0, 7)), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d step%0d: got %h expected %h", i, j, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            cycle(b, 3'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0));
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", i, j, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b0;
        throw  = 3'd0;
        test_reset();
        test_blink();
        test_doubles();
        test_sanitise();
        test_reset_mid_roll();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_result_display.md
Name: dice_result_display

Overview:
- Downstream stage of the electronic dice.
- Consumes the dice's live `throw` value and the same `button` that drives the dice.
- While the button is held, it shows a blinking "rolling" display. On release, it captures the final throw, then drives a 7-segment digit with it, flags doubles and counts rolls.
- Feeds board LEDs / 7-segment pins and any score logic further downstream.

Parameters:
- BLINK_DIV, 4, clock cycles per blink phase while rolling (legal range 1..255).
- COUNT_W, 8, width of the saturating roll counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- button  input  1  roll button, already clean and synchronous to clk; the same net feeds the dice
- throw  input  3  live dice value from the dice block
- seg  output  7  active-high segments {g,f,e,d,c,b,a}
- result  output  3  last captured throw, always 1..6 once valid
- result_valid  output  1  one-cycle pulse on the cycle a new result is captured
- doubles  output  1  level: latest result equals the previous one
- roll_count  output  COUNT_W  completed rolls since reset, saturating
- rolling  output  1  high while in ROLLING

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, result=0, result_valid=0, doubles=0, roll_count=0.
  - prev_valid=0, blink counter=0, blink_on=1.
  - rst has priority over every other event, including mid-roll. No capture happens on the reset edge.
- Sanitise function san(t): 1..6 pass through; 0 and 7 map to 1.
- State IDLE: no result yet.
  - Stays in IDLE while button=0.
  - button=1 at an edge -> ROLLING.
- State ROLLING:
  - Entry (the transition edge) loads blink counter=0 and blink_on=1.
  - Each edge in ROLLING with button=1: counter increments. When counter==BLINK_DIV-1, counter returns to 0 and blink_on toggles.
  - Edge with button=0 (release):
    - result <= san(throw), sampled on that edge.
    - result_valid <= 1 for exactly one cycle.
    - doubles <= (prev_valid && san(throw)==result_old); prev_valid <= 1.
    - roll_count <= roll_count+1, holding at all-ones.
    - state -> SHOW.
- State SHOW:
  - Holds result, doubles and roll_count.
  - button=1 at an edge -> ROLLING. result, doubles and roll_count are retained; result_valid stays 0.
- rolling output: 1 exactly when state==ROLLING (registered state, no combinational path from button).
- result_valid is 0 in every cycle other than the one following the capture edge.
- seg is a combinational decode of the registered state, blink_on, result and live throw:
  - IDLE -> 7'h40 (dash).
  - ROLLING -> digit(san(throw)) if blink_on, else 7'h00.
  - SHOW -> digit(result).
- Digit codes: 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D.
- A one-cycle button pulse gives ROLLING for exactly one cycle, then a capture. This is a legal roll.
- Capture latency: result/result_valid visible in the cycle immediately after the release edge.

Test Plan:
- rst=1 for 2 cycles with button=1 -> state IDLE, seg=7'h40, result=0, roll_count=0, result_valid=0 throughout.
- Release rst, button=1 for 10 cycles, throw held at 3 by the bench, BLINK_DIV=4:
  - rolling=1 from the first edge.
  - seg alternates 7'h4F for 4 cycles and 7'h00 for 4 cycles.
  - Then button=0 -> one-cycle result_valid, result=3, seg=7'h4F, roll_count=1, doubles=0.
- Second roll ending with throw=3 -> doubles=1, roll_count=2. Third roll ending with throw=5 -> doubles=0, result=5, seg=7'h6D.
- Roll ending with throw=0, then another with throw=7 -> result=1 both times, seg=7'h06, second capture sets doubles=1.
- Assert rst while rolling (button=1) -> next cycle state IDLE, seg=7'h40, no result_valid pulse, roll_count=0; releasing button afterwards does not capture.
- Force roll_count to saturation (COUNT_W=2 build, 5 rolls) -> roll_count reads 1,2,3,3,3.
